// File: rtl/dmem_access_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_access_ctrl
//  Sequences a single load or store between the core datapath and data memory
//  over a req/gnt/rvalid bus. Store data is shifted into its byte lanes and
//  byte enables are derived from the access width and address offset. Load
//  data is returned shifted down to bit 0; sign/zero extension happens in a
//  later format stage. Misaligned/illegal accesses are rejected without any
//  bus activity, and a bus that never grants or answers is aborted after
//  TIMEOUT_CYCLES cycles (0 disables the timeout).
//
// Ports
//  clk, rst_n        clock (rising edge), asynchronous active-low reset
//  req_valid_in      core request; accepted only while req_ready_out (IDLE)
//  req_ready_out     high in IDLE
//  we_in             1 = store, 0 = load
//  func3_in          RV32 width code: 0 B, 1 H, 2 W, 4 BU, 5 HU
//  addr_in           byte address
//  wdata_in          right-aligned store data
//  rsp_valid_out     one-cycle completion pulse
//  rdata_out         load data shifted to bit 0 (0 for stores and errors)
//  misalign_err_out  misaligned/illegal access, qualified by rsp_valid_out
//  timeout_err_out   bus timeout, qualified by rsp_valid_out
//  mem_req_out       bus request (REQ state)
//  mem_gnt_in        bus grant
//  mem_we_out        bus write enable
//  mem_addr_out      word-aligned bus address
//  mem_be_out        byte enables
//  mem_wdata_out     lane-shifted store data
//  mem_rvalid_in     read data valid / write acknowledge
//  mem_rdata_in      read data word
// ----------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int ARCH           = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  we_in,
  input  logic [2:0]            func3_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [ARCH-1:0]       wdata_in,
  output logic                  rsp_valid_out,
  output logic [ARCH-1:0]       rdata_out,
  output logic                  misalign_err_out,
  output logic                  timeout_err_out,
  output logic                  mem_req_out,
  input  logic                  mem_gnt_in,
  output logic                  mem_we_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [ARCH/8-1:0]     mem_be_out,
  output logic [ARCH-1:0]       mem_wdata_out,
  input  logic                  mem_rvalid_in,
  input  logic [ARCH-1:0]       mem_rdata_in
);

  localparam int BE_W  = ARCH / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_we;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ARCH-1:0]       r_wdata;
  logic                  r_rsp_valid;
  logic [ARCH-1:0]       r_rdata;
  logic                  r_misalign;
  logic                  r_timeout;

  logic                  w_bad;
  logic                  w_in_req;
  logic                  w_expire;
  logic [OFF_W+2:0]      w_shift;
  logic [BE_W-1:0]       w_be;

  // Only size codes 0/1/2 (plus unsigned 4/5 for loads) exist; stores have
  // no unsigned variant, and H/W must sit on their natural boundary.
  always_comb begin
    w_bad = 1'b0;
    case (func3_in)
      3'd0:    w_bad = 1'b0;
      3'd1:    w_bad = addr_in[0];
      3'd2:    w_bad = (addr_in[OFF_W-1:0] != '0);
      3'd4:    w_bad = we_in;
      3'd5:    w_bad = we_in | addr_in[0];
      default: w_bad = 1'b1;
    endcase
  end

  // Lane offset in bits, shared by the store and load shifters.
  assign w_shift = {r_addr[OFF_W-1:0], 3'b000};

  always_comb begin
    w_be = '0;
    case (r_size)
      2'd0:    w_be = BE_W'(1) << r_addr[OFF_W-1:0];
      2'd1:    w_be = BE_W'(3) << r_addr[OFF_W-1:0];
      default: w_be = '1;
    endcase
  end

  // Timeout fires on the last allowed cycle only when no exit event arrives,
  // so a grant/rvalid on that same cycle still wins.
  assign w_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);
  assign w_in_req = (r_state == S_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_size      <= 2'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_misalign  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      // Response outputs are zero everywhere except the single RESP cycle.
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_misalign  <= 1'b0;
      r_timeout   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid_in) begin
            r_we    <= we_in;
            r_size  <= func3_in[1:0];
            r_addr  <= addr_in;
            r_wdata <= wdata_in;
            if (w_bad) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_misalign  <= 1'b1;
            end else begin
              r_state <= S_REQ;
              r_cnt   <= '0;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt_in) begin
            r_state <= S_WAIT;
          end else if (w_expire) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_timeout   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (mem_rvalid_in) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rdata     <= r_we ? '0 : (mem_rdata_in >> w_shift);
          end else if (w_expire) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_timeout   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_out    = (r_state == S_IDLE);
  assign rsp_valid_out    = r_rsp_valid;
  assign rdata_out        = r_rdata;
  assign misalign_err_out = r_misalign;
  assign timeout_err_out  = r_timeout;

  // Bus fields are driven only while requesting so idle/reset show all zeros.
  assign mem_req_out   = w_in_req;
  assign mem_we_out    = w_in_req & r_we;
  assign mem_addr_out  = w_in_req ? {r_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_be_out    = w_in_req ? w_be : '0;
  assign mem_wdata_out = w_in_req ? (r_wdata << w_shift) : '0;

endmodule
